checkpointed_register_file: RTL and testbench
=============================================

// Module: checkpointed_register_file
// PURPOSE
//  Architectural register file + register status table (RST) for the Tomasulo core, generalised to
//  N_READ rename read ports, N_CDB broadcast buses and up to N_CKPT nested speculative branches.
//  Sits between instruction queue (rename/read at dispatch) and CDB arbiter (writeback). Each
//  in-flight branch owns a snapshot held in an in-order checkpoint FIFO; mispredict restores the oldest.
// PARAMETERS
//  BW_PROCESSOR_DATA  32  data width
//  BW_TAG             4   RS tag width; tag 0 = "value ready"
//  N_REG              32  architectural regs incl. x0 (x0 not stored, reads 0/0)
//  N_READ             2   source-operand read ports
//  N_CDB              2   CDB buses snooped per cycle
//  N_CKPT             4   max outstanding unresolved branches (>=1)
// PORTS
//  clk                 in   1                      clock
//  rst_n               in   1                      async active-low reset
//  i_iq_valid          in   1                      rename request this cycle
//  i_iq_rs_flatten     in   N_READ*log2(N_REG)     source reg indices, port k at [k*W +: W]
//  o_iq_Q_flatten      out  N_READ*BW_TAG          source tags (0 = ready)
//  o_iq_V_flatten      out  N_READ*BW_PROCESSOR_DATA source values (valid when Q==0)
//  i_iq_rd             in   log2(N_REG)            dest reg (0 = no write)
//  i_iq_tag            in   BW_TAG                 tag of renaming instruction (nonzero)
//  i_ckpt_valid        in   1                      dispatching branch: push snapshot
//  o_ckpt_full         out  1                      N_CKPT checkpoints held; IQ must not push
//  o_ckpt_count        out  log2(N_CKPT)+1         checkpoints held
//  i_branch_valid      in   1                      oldest branch resolved
//  i_branch_correct_prediction in 1                1 = correct, 0 = mispredict
//  i_cdb_valid         in   N_CDB                  per-bus valid
//  i_cdb_tag_flatten   in   N_CDB*BW_TAG           per-bus tag
//  i_cdb_wdata_flatten in   N_CDB*BW_PROCESSOR_DATA per-bus data
// BEHAVIOUR
//  - Reset: all RST entries 0, all values 0, checkpoint FIFO empty; o_ckpt_count=0, o_ckpt_full=0.
//  - Reads combinational, 0 latency. rs==0 -> Q=0,V=0. CDB bypass: valid bus tag == RST tag of rs
//    -> Q=0,V=that bus data. Same-cycle rename is NOT visible to reads (reads see pre-rename state).
//  - Next-state order within one cycle: (1) base = restored oldest ckpt if flush else current;
//    (2) every CDB bus clears matching tags in base and in every held ckpt (Q->0, V->data);
//    (3) rename: i_iq_valid && rd!=0 && !flush -> RST[rd]=i_iq_tag (overrides CDB hit on rd);
//    (4) push: i_ckpt_valid && !flush -> append copy of post-(3) state (branch's own rd, e.g. JAL link,
//        is inside the snapshot).
//  - flush = i_branch_valid && !correct: load oldest ckpt (after CDB), empty FIFO, drop rename/push.
//  - correct resolve: pop oldest ckpt. Pop+push same cycle legal even when full (count unchanged).
//  - i_branch_valid with count==0, push when full without pop, two CDB buses with same nonzero tag:
//    illegal; assertions fire, state unspecified. CDB tag 0 ignored.
//  - FIFO: circular, head/tail pointers wrap modulo N_CKPT; count 0..N_CKPT; o_ckpt_full=(count==N_CKPT).
//  - Reset asserted mid-operation clears everything immediately, no in-flight state survives.
// TESTING
//  1 Reset, rename x5 tag 3, read x5 next cycle -> Q=3; CDB bus1 tag 3 data 0x55 -> bypass Q=0,V=0x55
//    same cycle, RST Q=0,V=0x55 next cycle.
//  2 Push ckpt, rename x1 tag 2, mispredict -> x1 Q returns to pre-branch value, count=0.
//  3 Push ckpt A, rename x2 t4, push B, rename x2 t5, correct, mispredict -> x2 Q=4 (restored from B).
//  4 Push ckpt with x3 tag 6 pending; CDB tag 6 data 0xAB; mispredict -> x3 Q=0,V=0xAB.
//  5 Fill N_CKPT=4 -> o_ckpt_full=1; pop+push same cycle -> count stays 4; reads of x0 always 0.
//  6 Rename x7 t1 and CDB tag 1 same cycle -> x7 Q=1 next cycle; flush+rename same cycle -> rename dropped.

Source files
------------

// File: rtl/checkpointed_register_file.sv
// checkpointed_register_file: architectural register file + RST with CDB snooping and an in-order branch checkpoint FIFO
module checkpointed_register_file #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG = 4,
  parameter int N_REG = 32,
  parameter int N_READ = 2,
  parameter int N_CDB = 2,
  parameter int N_CKPT = 4,
  localparam int RW = $clog2(N_REG),
  localparam int CW = $clog2(N_CKPT) + 1,
  localparam int PW = (N_CKPT > 1) ? $clog2(N_CKPT) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_iq_valid,
  input  logic [N_READ*RW-1:0]                i_iq_rs_flatten,
  output logic [N_READ*BW_TAG-1:0]            o_iq_Q_flatten,
  output logic [N_READ*BW_PROCESSOR_DATA-1:0] o_iq_V_flatten,
  input  logic [RW-1:0]                       i_iq_rd,
  input  logic [BW_TAG-1:0]                   i_iq_tag,
  input  logic                                i_ckpt_valid,
  output logic                                o_ckpt_full,
  output logic [CW-1:0]                       o_ckpt_count,
  input  logic                                i_branch_valid,
  input  logic                                i_branch_correct_prediction,
  input  logic [N_CDB-1:0]                    i_cdb_valid,
  input  logic [N_CDB*BW_TAG-1:0]             i_cdb_tag_flatten,
  input  logic [N_CDB*BW_PROCESSOR_DATA-1:0]  i_cdb_wdata_flatten
);
  logic [BW_TAG-1:0]            q_q [N_REG];
  logic [BW_TAG-1:0]            q_d [N_REG];
  logic [BW_PROCESSOR_DATA-1:0] v_q [N_REG];
  logic [BW_PROCESSOR_DATA-1:0] v_d [N_REG];
  logic [BW_TAG-1:0]            ckq_q [N_CKPT][N_REG];
  logic [BW_TAG-1:0]            ckq_d [N_CKPT][N_REG];
  logic [BW_PROCESSOR_DATA-1:0] ckv_q [N_CKPT][N_REG];
  logic [BW_PROCESSOR_DATA-1:0] ckv_d [N_CKPT][N_REG];
  logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                count_q, count_d;
  logic [BW_TAG-1:0]            cdb_tag [N_CDB];
  logic [BW_PROCESSOR_DATA-1:0] cdb_data [N_CDB];
  logic [RW-1:0]                rs [N_READ];
  logic                         flush, pop, push, ren, dup;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(N_CKPT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign flush = i_branch_valid && !i_branch_correct_prediction;
  assign pop = i_branch_valid && i_branch_correct_prediction;
  assign push = i_ckpt_valid && !flush;
  assign ren = i_iq_valid && (i_iq_rd != '0) && !flush;
  assign o_ckpt_count = count_q;
  assign o_ckpt_full = (count_q == CW'(N_CKPT));

  // unpack CDB buses and flag two buses broadcasting the same nonzero tag
  always_comb begin
    dup = 1'b0;
    for (int b = 0; b < N_CDB; b++) begin
      cdb_tag[b] = i_cdb_tag_flatten[b*BW_TAG +: BW_TAG];
      cdb_data[b] = i_cdb_wdata_flatten[b*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
    end
    for (int a = 0; a < N_CDB; a++)
      for (int b = a + 1; b < N_CDB; b++)
        if (i_cdb_valid[a] && i_cdb_valid[b] && cdb_tag[a] != '0 && cdb_tag[a] == cdb_tag[b]) dup = 1'b1;
  end

  // combinational operand read: pre-rename state with same-cycle CDB bypass, x0 hardwired to ready/0
  always_comb begin
    o_iq_Q_flatten = '0;
    o_iq_V_flatten = '0;
    for (int k = 0; k < N_READ; k++) begin
      rs[k] = i_iq_rs_flatten[k*RW +: RW];
      if (rs[k] != '0) begin
        o_iq_Q_flatten[k*BW_TAG +: BW_TAG] = q_q[rs[k]];
        o_iq_V_flatten[k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA] = v_q[rs[k]];
        for (int b = 0; b < N_CDB; b++)
          if (i_cdb_valid[b] && cdb_tag[b] != '0 && cdb_tag[b] == q_q[rs[k]]) begin
            o_iq_Q_flatten[k*BW_TAG +: BW_TAG] = '0;
            o_iq_V_flatten[k*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA] = cdb_data[b];
          end
      end
    end
  end

  // next state: restore-or-keep, CDB wakeup everywhere, rename, then snapshot push
  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      q_d[r] = flush ? ckq_q[head_q][r] : q_q[r];
      v_d[r] = flush ? ckv_q[head_q][r] : v_q[r];
      for (int b = 0; b < N_CDB; b++)
        if (i_cdb_valid[b] && cdb_tag[b] != '0 && cdb_tag[b] == q_d[r]) begin
          q_d[r] = '0;
          v_d[r] = cdb_data[b];
        end
    end
    for (int c = 0; c < N_CKPT; c++)
      for (int r = 0; r < N_REG; r++) begin
        ckq_d[c][r] = ckq_q[c][r];
        ckv_d[c][r] = ckv_q[c][r];
        for (int b = 0; b < N_CDB; b++)
          if (i_cdb_valid[b] && cdb_tag[b] != '0 && cdb_tag[b] == ckq_d[c][r]) begin
            ckq_d[c][r] = '0;
            ckv_d[c][r] = cdb_data[b];
          end
      end
    if (ren) q_d[i_iq_rd] = i_iq_tag;
    q_d[0] = '0;
    v_d[0] = '0;
    if (push)
      for (int r = 0; r < N_REG; r++) begin
        ckq_d[tail_q][r] = q_d[r];
        ckv_d[tail_q][r] = v_d[r];
      end
    head_d = flush ? '0 : pop ? inc(head_q) : head_q;
    tail_d = flush ? '0 : push ? inc(tail_q) : tail_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end

  // state registers; async reset wipes RST, values and all checkpoints
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_REG; r++) begin
        q_q[r] <= '0;
        v_q[r] <= '0;
      end
      for (int c = 0; c < N_CKPT; c++)
        for (int r = 0; r < N_REG; r++) begin
          ckq_q[c][r] <= '0;
          ckv_q[c][r] <= '0;
        end
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      q_q <= q_d;
      v_q <= v_d;
      ckq_q <= ckq_d;
      ckv_q <= ckv_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end

  a_resolve_nonempty: assert property (@(posedge clk) disable iff (!rst_n) i_branch_valid |-> count_q != '0);
  a_push_not_full: assert property (@(posedge clk) disable iff (!rst_n) (i_ckpt_valid && o_ckpt_full) |-> i_branch_valid);
  a_cdb_unique: assert property (@(posedge clk) disable iff (!rst_n) !dup);
endmodule

// File: tb/tb_checkpointed_register_file.sv
// tb_checkpointed_register_file: scenario tasks with a read-expectation scoreboard
module tb_checkpointed_register_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iq_valid;
  logic [9:0]  rs_flat;
  logic [7:0]  q_flat;
  logic [63:0] v_flat;
  logic [4:0]  iq_rd;
  logic [3:0]  iq_tag;
  logic        ckpt_valid, ckpt_full, br_valid, br_correct;
  logic [2:0]  ckpt_count;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;

  typedef struct { string name; int port; logic [3:0] q; logic [31:0] v; bit chkv; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          passed = 0, total = 0;
  logic [3:0]  gq;
  logic [31:0] gv;

  always #5 clk = ~clk;

  checkpointed_register_file dut (
    .clk(clk), .rst_n(rst_n), .i_iq_valid(iq_valid), .i_iq_rs_flatten(rs_flat),
    .o_iq_Q_flatten(q_flat), .o_iq_V_flatten(v_flat), .i_iq_rd(iq_rd), .i_iq_tag(iq_tag),
    .i_ckpt_valid(ckpt_valid), .o_ckpt_full(ckpt_full), .o_ckpt_count(ckpt_count),
    .i_branch_valid(br_valid), .i_branch_correct_prediction(br_correct),
    .i_cdb_valid(cdb_valid), .i_cdb_tag_flatten(cdb_tag), .i_cdb_wdata_flatten(cdb_data)
  );

  task automatic idle();
    iq_valid = 0; rs_flat = '0; iq_rd = '0; iq_tag = '0; ckpt_valid = 0;
    br_valid = 0; br_correct = 0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #3;
    rst_n = 1;
    tick();
  endtask

  task automatic rename(input logic [4:0] r, input logic [3:0] t);
    iq_valid = 1; iq_rd = r; iq_tag = t;
  endtask

  task automatic cdb(input int bus, input logic [3:0] t, input logic [31:0] d);
    cdb_valid[bus] = 1'b1; cdb_tag[bus*4 +: 4] = t; cdb_data[bus*32 +: 32] = d;
  endtask

  task automatic mispredict();
    br_valid = 1; br_correct = 0;
  endtask

  task automatic expect_rd(input int port, input logic [4:0] r, input logic [3:0] q,
                           input logic [31:0] v, input bit chkv, input string name);
    exp_t x;
    rs_flat[port*5 +: 5] = r;
    x.name = name; x.port = port; x.q = q; x.v = v; x.chkv = chkv;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    expect_rd(0, 5'd5, 4'd0, 32'd0, 1, "rst_x5");
    expect_rd(1, 5'd31, 4'd0, 32'd0, 1, "rst_x31");
    #12;
    total++; if (ckpt_count !== 3'd0) $display("FAIL rst_count: got %0d, need 0", ckpt_count); else passed++;
    total++; if (ckpt_full !== 1'b0) $display("FAIL rst_full: got %b, need 0", ckpt_full); else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_rename_bypass();
    do_reset();
    rename(5, 3); tick(); idle();
    expect_rd(0, 5'd5, 4'd3, 32'd0, 0, "t1_renamed");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    cdb(1, 3, 32'h55);
    expect_rd(1, 5'd5, 4'd0, 32'h55, 1, "t1_bypass");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    tick(); idle();
    expect_rd(0, 5'd5, 4'd0, 32'h55, 1, "t1_written");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    rename(1, 7); tick(); idle();
    ckpt_valid = 1; tick(); idle();
    total++; if (ckpt_count !== 3'd1) $display("FAIL t2_count_push: got %0d, need 1", ckpt_count); else passed++;
    rename(1, 2); tick(); idle();
    expect_rd(0, 5'd1, 4'd2, 32'd0, 0, "t2_renamed");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    idle(); mispredict(); tick(); idle();
    expect_rd(0, 5'd1, 4'd7, 32'd0, 0, "t2_restored");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    total++; if (ckpt_count !== 3'd0) $display("FAIL t2_count_flush: got %0d, need 0", ckpt_count); else passed++;
  endtask

  task automatic test_nested();
    do_reset();
    ckpt_valid = 1; tick(); idle();
    rename(2, 4); tick(); idle();
    ckpt_valid = 1; tick(); idle();
    rename(2, 5); tick(); idle();
    total++; if (ckpt_count !== 3'd2) $display("FAIL t3_count2: got %0d, need 2", ckpt_count); else passed++;
    br_valid = 1; br_correct = 1; tick(); idle();
    total++; if (ckpt_count !== 3'd1) $display("FAIL t3_count_pop: got %0d, need 1", ckpt_count); else passed++;
    mispredict(); tick(); idle();
    expect_rd(0, 5'd2, 4'd4, 32'd0, 0, "t3_from_B");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
  endtask

  task automatic test_ckpt_cdb();
    do_reset();
    rename(3, 6); tick(); idle();
    ckpt_valid = 1; tick(); idle();
    cdb(0, 6, 32'hAB); tick(); idle();
    mispredict(); tick(); idle();
    expect_rd(0, 5'd3, 4'd0, 32'hAB, 1, "t4_ckpt_woken");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    idle(); rename(3, 8); tick(); idle();
    ckpt_valid = 1; tick(); idle();
    mispredict(); cdb(1, 8, 32'hCD); tick(); idle();
    expect_rd(1, 5'd3, 4'd0, 32'hCD, 1, "t4_flush_plus_cdb");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rename(10, 4'(i + 1)); ckpt_valid = 1; tick(); idle();
    end
    total++; if (ckpt_full !== 1'b0 || ckpt_count !== 3'd3) $display("FAIL t5_three: got full=%b count=%0d, need full=0 count=3", ckpt_full, ckpt_count); else passed++;
    rename(10, 4); ckpt_valid = 1; tick(); idle();
    total++; if (ckpt_full !== 1'b1 || ckpt_count !== 3'd4) $display("FAIL t5_full: got full=%b count=%0d, need full=1 count=4", ckpt_full, ckpt_count); else passed++;
    rename(10, 9); ckpt_valid = 1; br_valid = 1; br_correct = 1; tick(); idle();
    total++; if (ckpt_full !== 1'b1 || ckpt_count !== 3'd4) $display("FAIL t5_pop_push: got full=%b count=%0d, need full=1 count=4", ckpt_full, ckpt_count); else passed++;
    cdb(0, 0, 32'hFFFF_FFFF); rename(0, 9);
    expect_rd(0, 5'd0, 4'd0, 32'd0, 1, "t5_x0_tag0_cdb");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      br_valid = 1; br_correct = 1; tick(); idle();
    end
    total++; if (ckpt_count !== 3'd1) $display("FAIL t5_drain: got %0d, need 1", ckpt_count); else passed++;
    mispredict(); tick(); idle();
    expect_rd(0, 5'd10, 4'd9, 32'd0, 0, "t5_wrapped_slot");
    expect_rd(1, 5'd0, 4'd0, 32'd0, 1, "t5_x0_after");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rename(7, 1); cdb(0, 1, 32'h11); tick(); idle();
    expect_rd(0, 5'd7, 4'd1, 32'd0, 0, "t6_rename_wins");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    cdb(1, 1, 32'h77);
    expect_rd(1, 5'd7, 4'd0, 32'h77, 1, "t6_bypass_p1");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    idle(); ckpt_valid = 1; tick(); idle();
    mispredict(); rename(8, 9); ckpt_valid = 1; tick(); idle();
    expect_rd(0, 5'd8, 4'd0, 32'd0, 1, "t6_flush_drops_rename");
    expect_rd(1, 5'd7, 4'd1, 32'd0, 0, "t6_x7_restored");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    total++; if (ckpt_count !== 3'd0) $display("FAIL t6_push_dropped: got %0d, need 0", ckpt_count); else passed++;
    idle(); ckpt_valid = 1; tick(); idle();
    #2;
    rst_n = 0;
    #1;
    expect_rd(0, 5'd7, 4'd0, 32'd0, 1, "t6_async_reset");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); gq = q_flat[e.port*4 +: 4]; gv = v_flat[e.port*32 +: 32]; total++;
      if (gq !== e.q || (e.chkv && gv !== e.v)) $display("FAIL %s: got Q=%0h V=%h, need Q=%0h V=%h", e.name, gq, gv, e.q, e.v); else passed++;
    end
    total++; if (ckpt_count !== 3'd0) $display("FAIL t6_async_count: got %0d, need 0", ckpt_count); else passed++;
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_rename_bypass();
    test_mispredict();
    test_nested();
    test_ckpt_cdb();
    test_full_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
